// File: rtl/fpnew_issue_rob.sv
// Issue/reorder front end for the FPNew FPU: tags requests on the way in and
// returns FPU results to the requester in issue order from a tag-indexed buffer.
module fpnew_issue_rob #(
    parameter int unsigned FLEN      = 16,
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [3*FLEN-1:0]      req_operands_i,
    input  logic [3:0]             req_op_i,
    input  logic                   req_op_mod_i,
    input  logic [2:0]             req_rnd_mode_i,
    output logic                   fpu_valid_o,
    input  logic                   fpu_ready_i,
    output logic [3*FLEN-1:0]      fpu_operands_o,
    output logic [3:0]             fpu_op_o,
    output logic                   fpu_op_mod_o,
    output logic [2:0]             fpu_rnd_mode_o,
    output logic [TAG_WIDTH-1:0]   fpu_tag_o,
    output logic                   fpu_flush_o,
    input  logic                   fpu_out_valid_i,
    output logic                   fpu_out_ready_o,
    input  logic [FLEN-1:0]        fpu_result_i,
    input  logic [4:0]             fpu_status_i,
    input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [FLEN-1:0]        resp_result_o,
    output logic [4:0]             resp_status_o,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
    localparam int unsigned CNT_W = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0] r_alloc_ptr;
    logic [TAG_WIDTH-1:0] r_head_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]     r_done;
    logic [FLEN-1:0]      r_result [DEPTH];
    logic [4:0]           r_status [DEPTH];
    logic                 r_err;

    logic                 w_full;
    logic                 w_fpu_valid;
    logic                 w_req_ready;
    logic                 w_issue_fire;
    logic                 w_resp_valid;
    logic                 w_retire;
    logic                 w_result_fire;
    logic [TAG_WIDTH-1:0] w_tag_offset;
    logic                 w_tag_alloc;
    logic                 w_result_ok;
    logic                 w_result_err;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [DEPTH-1:0]     w_done_nxt;

    // Handshake decode; a returning tag is legal only inside the window [head, head+count).
    always_comb begin
        w_full        = (r_count == CNT_W'(DEPTH));
        w_fpu_valid   = rst_ni & req_valid_i & ~w_full & ~flush_i;
        w_req_ready   = rst_ni & fpu_ready_i & ~w_full & ~flush_i;
        w_issue_fire  = w_fpu_valid & fpu_ready_i;
        w_resp_valid  = (r_count != {CNT_W{1'b0}}) & r_done[r_head_ptr];
        w_retire      = w_resp_valid & resp_ready_i;
        w_result_fire = rst_ni & fpu_out_valid_i & ~flush_i;
        w_tag_offset  = fpu_tag_i - r_head_ptr;
        w_tag_alloc   = ({1'b0, w_tag_offset} < r_count);
        w_result_ok   = w_result_fire & w_tag_alloc & ~r_done[fpu_tag_i];
        w_result_err  = w_result_fire & ~(w_tag_alloc & ~r_done[fpu_tag_i]);
    end

    // Occupancy update; simultaneous issue and retire leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_issue_fire, w_retire})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Done-bit update; the three sources never touch the same entry in one cycle.
    always_comb begin
        w_done_nxt = r_done;
        if (w_issue_fire) begin
            w_done_nxt[r_alloc_ptr] = 1'b0;
        end else begin
            w_done_nxt = w_done_nxt;
        end
        if (w_retire) begin
            w_done_nxt[r_head_ptr] = 1'b0;
        end else begin
            w_done_nxt = w_done_nxt;
        end
        if (w_result_ok) begin
            w_done_nxt[fpu_tag_i] = 1'b1;
        end else begin
            w_done_nxt = w_done_nxt;
        end
    end

    // Control state: pointers, occupancy, done bits and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alloc_ptr <= {TAG_WIDTH{1'b0}};
            r_head_ptr  <= {TAG_WIDTH{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_done      <= {DEPTH{1'b0}};
            r_err       <= 1'b0;
        end else if (flush_i) begin
            r_alloc_ptr <= {TAG_WIDTH{1'b0}};
            r_head_ptr  <= {TAG_WIDTH{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_done      <= {DEPTH{1'b0}};
        end else begin
            if (w_issue_fire) begin
                r_alloc_ptr <= r_alloc_ptr + TAG_WIDTH'(1);
            end
            if (w_retire) begin
                r_head_ptr <= r_head_ptr + TAG_WIDTH'(1);
            end
            if (w_result_err) begin
                r_err <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Result storage, written only for a legal first return of an allocated tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i] <= {FLEN{1'b0}};
                r_status[i] <= 5'b00000;
            end
        end else if (w_result_ok) begin
            r_result[fpu_tag_i] <= fpu_result_i;
            r_status[fpu_tag_i] <= fpu_status_i;
        end
    end

    // Output drive; payloads are zeroed whenever their valid is low.
    always_comb begin
        fpu_valid_o     = w_fpu_valid;
        req_ready_o     = w_req_ready;
        fpu_flush_o     = rst_ni & flush_i;
        fpu_out_ready_o = rst_ni;
        resp_valid_o    = w_resp_valid;
        busy_o          = (r_count != {CNT_W{1'b0}});
        err_o           = r_err;
        if (w_fpu_valid) begin
            fpu_operands_o = req_operands_i;
            fpu_op_o       = req_op_i;
            fpu_op_mod_o   = req_op_mod_i;
            fpu_rnd_mode_o = req_rnd_mode_i;
            fpu_tag_o      = r_alloc_ptr;
        end else begin
            fpu_operands_o = {(3*FLEN){1'b0}};
            fpu_op_o       = 4'b0000;
            fpu_op_mod_o   = 1'b0;
            fpu_rnd_mode_o = 3'b000;
            fpu_tag_o      = {TAG_WIDTH{1'b0}};
        end
        if (w_resp_valid) begin
            resp_result_o = r_result[r_head_ptr];
            resp_status_o = r_status[r_head_ptr];
        end else begin
            resp_result_o = {FLEN{1'b0}};
            resp_status_o = 5'b00000;
        end
    end

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Self-checking bench for fpnew_issue_rob: acts as requester and FPU, with a
// scoreboard holding expected responses in issue order.
module tb_fpnew_issue_rob;

    localparam int FLEN = 16;
    localparam int TW   = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3*FLEN-1:0] req_operands_i;
    logic [3:0]        req_op_i;
    logic              req_op_mod_i;
    logic [2:0]        req_rnd_mode_i;
    logic              fpu_valid_o;
    logic              fpu_ready_i;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_rnd_mode_o;
    logic [TW-1:0]     fpu_tag_o;
    logic              fpu_flush_o;
    logic              fpu_out_valid_i;
    logic              fpu_out_ready_o;
    logic [FLEN-1:0]   fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic [TW-1:0]     fpu_tag_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [FLEN-1:0]   resp_result_o;
    logic [4:0]        resp_status_o;
    logic              flush_i;
    logic              busy_o;
    logic              err_o;

    fpnew_issue_rob #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i),
        .req_op_mod_i(req_op_mod_i), .req_rnd_mode_i(req_rnd_mode_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
        .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
        .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .fpu_tag_i(fpu_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_status_o(resp_status_o),
        .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3*FLEN-1:0] ops;
        logic [3:0]        op;
        logic              mod;
        logic [2:0]        rnd;
        logic [FLEN-1:0]   res;
        logic [4:0]        st;
    } vec_t;

    typedef struct {
        logic [FLEN-1:0] res;
        logic [4:0]      st;
    } exp_t;

    vec_t            vecs [6];
    exp_t            sb [$];
    logic [FLEN-1:0] tag_res [4];
    logic [4:0]      tag_st  [4];
    logic [TW-1:0]   exp_alloc;
    logic [TW-1:0]   base;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i     = 1'b0;
        req_operands_i  = '0;
        req_op_i        = 4'd0;
        req_op_mod_i    = 1'b0;
        req_rnd_mode_i  = 3'd0;
        fpu_ready_i     = 1'b1;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = 5'd0;
        fpu_tag_i       = '0;
        resp_ready_i    = 1'b0;
        flush_i         = 1'b0;
    endtask

    // Issue one op and record the result the modelled FPU will return for its tag.
    task automatic issue(input logic [3*FLEN-1:0] ops, input logic [3:0] op, input logic mod,
                         input logic [2:0] rnd, input logic [FLEN-1:0] res, input logic [4:0] st);
        exp_t e;
        req_valid_i = 1'b1; req_operands_i = ops; req_op_i = op;
        req_op_mod_i = mod; req_rnd_mode_i = rnd;
        #1;
        chk("issue_valid", 64'(fpu_valid_o), 64'd1);
        chk("issue_ready", 64'(req_ready_o), 64'd1);
        chk("issue_tag", 64'(fpu_tag_o), 64'(exp_alloc));
        chk("issue_ops", 64'(fpu_operands_o), 64'(ops));
        chk("issue_ctl", 64'({fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o}), 64'({op, mod, rnd}));
        tag_res[exp_alloc] = res;
        tag_st[exp_alloc]  = st;
        e.res = res; e.st = st;
        sb.push_back(e);
        exp_alloc = exp_alloc + 2'd1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic fpu_ret(input logic [TW-1:0] tag);
        fpu_out_valid_i = 1'b1; fpu_tag_i = tag;
        fpu_result_i = tag_res[tag]; fpu_status_i = tag_st[tag];
        #1;
        chk("out_ready", 64'(fpu_out_ready_o), 64'd1);
        tick();
        fpu_out_valid_i = 1'b0;
    endtask

    task automatic retire_check();
        exp_t e;
        resp_ready_i = 1'b1;
        #1;
        chk("resp_valid", 64'(resp_valid_o), 64'd1);
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty: got response expected none");
        end else begin
            e = sb.pop_front();
            chk("resp_result", 64'(resp_result_o), 64'(e.res));
            chk("resp_status", 64'(resp_status_o), 64'(e.st));
        end
        tick();
        resp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{48'h4000_3C00_0000, 4'd2, 1'b0, 3'd0, 16'h4200, 5'b00000};
        vecs[1] = '{48'h4400_4000_0000, 4'd2, 1'b1, 3'd1, 16'h4000, 5'b00001};
        vecs[2] = '{48'h0000_3C00_4000, 4'd3, 1'b0, 3'd2, 16'h4000, 5'b00000};
        vecs[3] = '{48'h3C00_4000_4200, 4'd0, 1'b0, 3'd3, 16'h4A00, 5'b00011};
        vecs[4] = '{48'h0000_0000_3C00, 4'd4, 1'b0, 3'd4, 16'h7E00, 5'b10000};
        vecs[5] = '{48'h0000_0000_0000, 4'd5, 1'b1, 3'd0, 16'h7C00, 5'b01000};
        exp_alloc = '0;

        // Reset: outputs low even with a pending request.
        idle();
        rst_ni = 1'b0;
        req_valid_i = 1'b1;
        #2;
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_fpu_valid", 64'(fpu_valid_o), 64'd0);
        chk("rst_misc", 64'({resp_valid_o, busy_o, err_o, fpu_flush_o, fpu_out_ready_o}), 64'd0);
        #18 rst_ni = 1'b1;
        idle();
        tick();
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // Table: single op round trip per vector, tags wrap past DEPTH.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].ops, vecs[i].op, vecs[i].mod, vecs[i].rnd, vecs[i].res, vecs[i].st);
            chk("vec_busy", 64'(busy_o), 64'd1);
            fpu_ret(exp_alloc - 2'd1);
            retire_check();
            chk("vec_idle", 64'(busy_o), 64'd0);
        end

        // Out-of-order return.
        base = exp_alloc;
        issue(48'h1, 4'd2, 1'b0, 3'd0, 16'h4000, 5'd0);
        issue(48'h2, 4'd2, 1'b0, 3'd0, 16'h4400, 5'd1);
        fpu_ret(base + 2'd1);
        chk("ooo_wait", 64'(resp_valid_o), 64'd0);
        fpu_ret(base);
        retire_check();
        retire_check();
        chk("ooo_idle", 64'(busy_o), 64'd0);

        // Full: four outstanding, retire one with a request pending, no bypass.
        base = exp_alloc;
        for (int i = 0; i < 4; i++) issue(48'(i), 4'd2, 1'b0, 3'd0, 16'h5000 + 16'(i), 5'(i));
        req_valid_i = 1'b1; req_operands_i = 48'hAAAA; req_op_i = 4'd1;
        #1;
        chk("full_valid", 64'(fpu_valid_o), 64'd0);
        chk("full_ready", 64'(req_ready_o), 64'd0);
        tick();
        fpu_ret(base);
        resp_ready_i = 1'b1;
        #1;
        chk("full_retire_blocked", 64'(fpu_valid_o), 64'd0);
        chk("full_resp", 64'(resp_result_o), 64'(sb[0].res));
        void'(sb.pop_front());
        tick();
        resp_ready_i = 1'b0;
        req_op_mod_i = 1'b0; req_rnd_mode_i = 3'd0;
        issue(48'hAAAA, 4'd1, 1'b0, 3'd0, 16'h5004, 5'd4);
        chk("wrap_alloc", 64'(exp_alloc), 64'(base + 2'd1));

        // Backpressure: all returned out of order, response held, then drained.
        fpu_ret(base);
        fpu_ret(base + 2'd3);
        fpu_ret(base + 2'd2);
        chk("bp_head_wait", 64'(resp_valid_o), 64'd0);
        fpu_ret(base + 2'd1);
        for (int i = 0; i < 2; i++) begin
            chk("bp_hold_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_hold_data", 64'(resp_result_o), 64'(sb[0].res));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            retire_check();
            chk("bp_gap", 64'(resp_valid_o), 64'(i < 3));
            tick();
        end
        chk("bp_idle", 64'(busy_o), 64'd0);

        // Flush with a concurrent result; pointers restart at tag 0.
        base = exp_alloc;
        for (int i = 0; i < 3; i++) issue(48'(i), 4'd2, 1'b0, 3'd0, 16'h6000, 5'd0);
        flush_i = 1'b1; req_valid_i = 1'b1;
        fpu_out_valid_i = 1'b1; fpu_tag_i = base; fpu_result_i = 16'h6000;
        #1;
        chk("flush_out", 64'(fpu_flush_o), 64'd1);
        chk("flush_blocks", 64'({fpu_valid_o, req_ready_o}), 64'd0);
        tick();
        idle();
        sb.delete();
        exp_alloc = '0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_err", 64'(err_o), 64'd0);
        chk("flush_resp", 64'(resp_valid_o), 64'd0);
        issue(48'h3C00, 4'd2, 1'b0, 3'd0, 16'h3C00, 5'd0);
        fpu_ret(2'd0);
        retire_check();

        // Error: stray tag 2 with only tag 0 allocated.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        exp_alloc = '0;
        issue(48'h1234, 4'd2, 1'b0, 3'd0, 16'h4800, 5'd0);
        tag_res[2] = 16'hDEAD; tag_st[2] = 5'd31;
        chk("err_before", 64'(err_o), 64'd0);
        fpu_ret(2'd2);
        chk("err_set", 64'(err_o), 64'd1);
        chk("err_no_resp", 64'(resp_valid_o), 64'd0);
        fpu_ret(2'd0);
        retire_check();
        chk("err_sticky", 64'(err_o), 64'd1);

        // Asynchronous reset mid-operation.
        issue(48'h5555, 4'd2, 1'b0, 3'd0, 16'h4000, 5'd0);
        req_valid_i = 1'b1; req_operands_i = 48'h7777;
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_issue", 64'({req_ready_o, fpu_valid_o, fpu_operands_o}), 64'd0);
        chk("arst_state", 64'({busy_o, err_o, resp_valid_o, fpu_out_ready_o}), 64'd0);
        #10 rst_ni = 1'b1;
        idle();
        sb.delete();
        exp_alloc = '0;
        tick();
        issue(48'h4000_3C00_0000, 4'd2, 1'b0, 3'd0, 16'h4200, 5'd0);
        fpu_ret(2'd0);
        retire_check();
        chk("final_idle", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpnew_issue_rob.md
Name: fpnew_issue_rob

Overview:
Initiator-side companion to the FPNew FPU blackbox. It accepts operation requests from an upstream accelerator datapath and issues them to the FPU's input valid/ready port with unique tags. It collects FPU results, which may return out of order across parallel units, in a tag-indexed reorder buffer (ROB). Results are returned to the requester strictly in issue order.

Parameters:
FLEN, 16, operand/result width in bits; must match the FPU instance.
TAG_WIDTH, 2, FPU tag width; ROB depth DEPTH = 2**TAG_WIDTH.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
req_operands_i  in  3*FLEN  operand triple {op2,op1,op0}, passed to FPU unchanged.
req_op_i  in  4  fpnew operation code, passed through.
req_op_mod_i  in  1  operation modifier, passed through.
req_rnd_mode_i  in  3  rounding mode, passed through.
fpu_valid_o  out  1  drives FPU in_valid_i.
fpu_ready_i  in  1  from FPU in_ready_o.
fpu_operands_o  out  3*FLEN  to FPU operands_i.
fpu_op_o  out  4  to FPU op_i.
fpu_op_mod_o  out  1  to FPU op_mod_i.
fpu_rnd_mode_o  out  3  to FPU rnd_mode_i.
fpu_tag_o  out  TAG_WIDTH  to FPU tag_i.
fpu_flush_o  out  1  to FPU flush_i.
fpu_out_valid_i  in  1  from FPU out_valid_o.
fpu_out_ready_o  out  1  to FPU out_ready_i.
fpu_result_i  in  FLEN  from FPU result_o.
fpu_status_i  in  5  from FPU status_o {NV,DZ,OF,UF,NX}.
fpu_tag_i  in  TAG_WIDTH  from FPU tag_o.
resp_valid_o  out  1  in-order response valid.
resp_ready_i  in  1  response consumed when resp_valid_o && resp_ready_i.
resp_result_o  out  FLEN  result of the oldest outstanding op.
resp_status_o  out  5  status of that op.
flush_i  in  1  abort all in-flight work.
busy_o  out  1  ROB occupancy count != 0.
err_o  out  1  sticky protocol error.

Behaviour:
- State: alloc_ptr, head_ptr (TAG_WIDTH bits each, wrap modulo DEPTH); count (0..DEPTH); per entry: done bit, result, status; err flag.
- Reset (async, rst_ni=0): pointers, count, done bits and err cleared. Outputs: req_ready_o=0, fpu_valid_o=0, resp_valid_o=0, busy_o=0, err_o=0, fpu_flush_o=0, fpu_out_ready_o=0. Data outputs are 0 while valid is low.
- Issue path is combinational with no registers:
  - full = (count==DEPTH).
  - fpu_valid_o = req_valid_i && !full && !flush_i.
  - req_ready_o = fpu_ready_i && !full && !flush_i.
  - Payload passes through; fpu_tag_o = alloc_ptr.
- Issue fire (fpu_valid_o && fpu_ready_i): alloc_ptr+1, count+1, and done[alloc_ptr] cleared.
- fpu_out_ready_o = 1 whenever not in reset. A slot is always reserved, so the FPU output is never stalled.
- Result fire: done[fpu_tag_i] is set and result/status are written.
  - If the tag is not currently allocated, or done is already set: err_o sets (sticky until reset) and the entry is unmodified.
- Response: resp_valid_o = done[head_ptr] && count!=0; resp_result_o and resp_status_o come from the head entry (registered source).
  - Latency: a result arriving at cycle t for the head tag gives resp_valid_o=1 at t+1.
- Retire (resp fire): done[head_ptr] cleared, head_ptr+1, count-1.
- Same-cycle issue and retire: count unchanged, both pointers advance.
- Full and retire in the same cycle: issue remains blocked that cycle (no bypass); issue is possible the next cycle.
- Result write to the head entry and retire of the head in the same cycle cannot occur, because done must already be set to retire.
- flush_i:
  - fpu_flush_o = flush_i (combinational); issue is blocked that cycle.
  - At the edge: pointers, count and done bits cleared; a result arriving that cycle is dropped; err_o is unchanged.
- Reset mid-operation: all in-flight work is discarded. The FPU is reset by the same rst_ni.

Test Plan:
- Single op: req ADD, operands {0x4000,0x3C00,0x0000}, fpu_ready_i=1 -> fpu_tag_o=0. FPU returns tag0, 0x4200, status 0 -> resp_valid_o=1 next cycle with 0x4200; busy_o drops after resp fire.
- Out-of-order return: issue tags 0 and 1; return tag1 (0x4400) then tag0 (0x4000) -> resp_valid_o stays 0 until tag0 arrives, then responses come 0x4000 then 0x4400 on consecutive cycles with resp_ready_i=1.
- Full: issue 4 ops with no returns -> req_ready_o=0 and fpu_valid_o=0 with req_valid_i=1. Retire one -> issue resumes the following cycle with fpu_tag_o=0 (wrap).
- Backpressure: hold resp_ready_i=0 with all 4 returned -> resp data stable at tag0. Toggle ready -> 4 responses in order, count returns to 0.
- Flush: 3 outstanding, flush_i pulse -> fpu_flush_o=1 that cycle, busy_o=0 next cycle. A concurrent result is dropped and err_o stays 0.
- Error: result with tag 2 when only tag0 is allocated -> err_o=1 next cycle and stays 1; rst_ni low mid-operation -> all outputs return to reset values asynchronously.
